// File: rtl/pc_sequencer.sv
// Purpose : program-counter sequencer; maps branch/jump/call/return/halt requests onto
//           the counter's load/offset controls and keeps a hardware return-address stack.
// Latency : zero-cycle controls (combinational from state + inputs); stack/FSM update on the same edge.
// Backpressure: Stall holds the PC and ignores all requests; no other flow control.
//
// Build option: define PC_SEQ_FLUSH_EN to insert a FLUSH state (Flush=1, requests ignored)
// in the cycle after every taken redirect. Undefined: redirects go straight back to RUN
// and Flush is tied low.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   CurrentPc           present counter value
//   Stall               hold PC, ignore requests
//   BranchReq/Taken/Offset  conditional relative branch
//   JumpReq, CallReq, Target  absolute jump / jump-and-push
//   ReturnReq           pop stack and load popped value
//   HaltReq, ResumeReq  enter / leave HALTED
//   LoadValue/LoadEnable, Offset/OffsetEnable  counter controls
//   Flush               discard the instruction in fetch
//   Fault               sticky stack overflow/underflow
//   StackCount          valid return-stack entries
module pc_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic signed [15:0]                    CurrentPc,
    input  logic                                  Stall,
    input  logic                                  BranchReq,
    input  logic                                  BranchTaken,
    input  logic signed [8:0]                     BranchOffset,
    input  logic                                  JumpReq,
    input  logic                                  CallReq,
    input  logic signed [15:0]                    Target,
    input  logic                                  ReturnReq,
    input  logic                                  HaltReq,
    input  logic                                  ResumeReq,
    output logic signed [15:0]                    LoadValue,
    output logic                                  LoadEnable,
    output logic signed [8:0]                     Offset,
    output logic                                  OffsetEnable,
    output logic                                  Flush,
    output logic                                  Fault,
    output logic [$clog2(STACK_DEPTH+1)-1:0]      StackCount
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

`ifdef PC_SEQ_FLUSH_EN
    typedef enum logic [1:0] {RUN, FLUSH, HALTED, FAULT} state_t;
    localparam state_t REDIRECT = FLUSH;
`else
    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
    localparam state_t REDIRECT = RUN;
`endif

    state_t state, state_nxt;

    logic signed [15:0] stack [STACK_DEPTH];
    logic               push;
    logic               pop;
    logic               stack_empty;
    logic               stack_full;
    logic [IW-1:0]      top_idx;
    logic [IW-1:0]      wr_idx;
    logic signed [15:0] ret_addr;

    assign stack_empty = (StackCount == '0);
    assign stack_full  = (StackCount == FULL);
    assign top_idx     = IW'(StackCount - ONE);
    assign wr_idx      = IW'(StackCount);
    // 16-bit add wraps naturally: 16'sh7FFF + 1 -> 16'sh8000
    assign ret_addr    = CurrentPc + 16'sd1;

    // Fault is suppressed during the reset cycle so every output reads 0 then.
    assign Fault = (state == FAULT) && !Reset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= RUN;
            StackCount <= '0;
        end else begin
            state <= state_nxt;
            if (push)
                StackCount <= StackCount + ONE;
            else if (pop)
                StackCount <= StackCount - ONE;
        end
    end

    // Stack contents are don't-care after reset; only StackCount qualifies them.
    always_ff @(posedge Clock) begin
        if (!Reset && push)
            stack[wr_idx] <= ret_addr;
    end

    always_comb begin
        state_nxt    = state;
        LoadValue    = '0;
        LoadEnable   = 1'b0;
        Offset       = '0;
        OffsetEnable = 1'b0;
        Flush        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        if (!Reset) begin
            case (state)
                RUN: begin
                    if (Stall) begin
                        OffsetEnable = 1'b1;
                    end else if (ReturnReq) begin
                        if (stack_empty) begin
                            OffsetEnable = 1'b1;
                            state_nxt    = FAULT;
                        end else begin
                            LoadValue  = stack[top_idx];
                            LoadEnable = 1'b1;
                            pop        = 1'b1;
                            state_nxt  = REDIRECT;
                        end
                    end else if (CallReq) begin
                        if (stack_full) begin
                            OffsetEnable = 1'b1;
                            state_nxt    = FAULT;
                        end else begin
                            LoadValue  = Target;
                            LoadEnable = 1'b1;
                            push       = 1'b1;
                            state_nxt  = REDIRECT;
                        end
                    end else if (JumpReq) begin
                        LoadValue  = Target;
                        LoadEnable = 1'b1;
                        state_nxt  = REDIRECT;
                    end else if (BranchReq) begin
                        // A taken branch with zero offset still counts as a redirect.
                        if (BranchTaken) begin
                            Offset       = BranchOffset;
                            OffsetEnable = 1'b1;
                            state_nxt    = REDIRECT;
                        end
                    end else if (HaltReq) begin
                        OffsetEnable = 1'b1;
                        state_nxt    = HALTED;
                    end
                end
`ifdef PC_SEQ_FLUSH_EN
                FLUSH: begin
                    Flush = 1'b1;
                    if (Stall)
                        OffsetEnable = 1'b1;
                    else
                        state_nxt = RUN;
                end
`endif
                HALTED: begin
                    // Resume only changes state; counting restarts on the next cycle.
                    OffsetEnable = 1'b1;
                    if (ResumeReq && !Stall)
                        state_nxt = RUN;
                end
                FAULT: begin
                    OffsetEnable = 1'b1;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : directed bench for pc_sequencer with a behavioural program counter in the loop.
// Latency : expected controls are queued when a step is driven and compared mid-cycle.
// Backpressure: exercises Stall in RUN and in the post-redirect cycle.
module tb_pc_sequencer;

`ifdef PC_SEQ_FLUSH_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic               Clock = 1'b0;
    logic               Reset;
    logic signed [15:0] CurrentPc;
    logic               Stall, BranchReq, BranchTaken, JumpReq, CallReq;
    logic               ReturnReq, HaltReq, ResumeReq;
    logic signed [8:0]  BranchOffset;
    logic signed [15:0] Target;
    logic signed [15:0] LoadValue;
    logic               LoadEnable;
    logic signed [8:0]  Offset;
    logic               OffsetEnable, Flush, Fault;
    logic [2:0]         StackCount;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        le;
        logic [15:0] lv;
        logic        oe;
        logic [8:0]  off;
        logic        fl;
        logic        ft;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(.STACK_DEPTH(4)) dut (
        .Clock(Clock), .Reset(Reset), .CurrentPc(CurrentPc), .Stall(Stall),
        .BranchReq(BranchReq), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
        .JumpReq(JumpReq), .CallReq(CallReq), .Target(Target), .ReturnReq(ReturnReq),
        .HaltReq(HaltReq), .ResumeReq(ResumeReq), .LoadValue(LoadValue),
        .LoadEnable(LoadEnable), .Offset(Offset), .OffsetEnable(OffsetEnable),
        .Flush(Flush), .Fault(Fault), .StackCount(StackCount)
    );

    always #5 Clock = ~Clock;

    // Program counter driven by the sequencer's controls.
    initial CurrentPc = 16'sd0;
    always @(posedge Clock) begin
        if (Reset)
            CurrentPc <= 16'sd0;
        else if (LoadEnable)
            CurrentPc <= LoadValue;
        else if (OffsetEnable)
            CurrentPc <= CurrentPc + Offset;
        else
            CurrentPc <= CurrentPc + 16'sd1;
    end

    function automatic exp_t mk(input logic le, input logic [15:0] lv, input logic oe,
                                input logic [8:0] off, input logic fl, input logic ft);
        exp_t e;
        e.le = le; e.lv = lv; e.oe = oe; e.off = off; e.fl = fl; e.ft = ft;
        return e;
    endfunction

    function automatic exp_t inc(input logic fl, input logic ft);
        return mk(1'b0, 16'h0, 1'b0, 9'h0, fl, ft);
    endfunction

    function automatic exp_t hold(input logic fl, input logic ft);
        return mk(1'b0, 16'h0, 1'b1, 9'h0, fl, ft);
    endfunction

    function automatic exp_t load(input logic [15:0] v);
        return mk(1'b1, v, 1'b0, 9'h0, 1'b0, 1'b0);
    endfunction

    task automatic clr();
        Reset = 1'b0; Stall = 1'b0; BranchReq = 1'b0; BranchTaken = 1'b0;
        BranchOffset = 9'sd0; JumpReq = 1'b0; CallReq = 1'b0; Target = 16'sd0;
        ReturnReq = 1'b0; HaltReq = 1'b0; ResumeReq = 1'b0;
    endtask

    // Inputs are already driven; queue the expected controls, compare at the
    // falling edge, then check the counter and stack depth after the rising edge.
    task automatic run(input string tag, input exp_t e, input logic [15:0] epc,
                       input logic [2:0] ecnt);
        exp_t ob, ex;
        sb.push_back(e);
        @(negedge Clock);
        ob.le = LoadEnable; ob.lv = LoadValue; ob.oe = OffsetEnable;
        ob.off = Offset; ob.fl = Flush; ob.ft = Fault;
        ex = sb.pop_front();
        total++;
        assert (ob === ex) else begin
            bad++;
            $error("FAIL %s ctrl got=%h want=%h (le,lv,oe,off,fl,ft)", tag, ob, ex);
        end
        @(posedge Clock);
        #1;
        total++;
        assert (CurrentPc === epc) else begin
            bad++;
            $error("FAIL %s pc got=%h want=%h", tag, CurrentPc, epc);
        end
        total++;
        assert (StackCount === ecnt) else begin
            bad++;
            $error("FAIL %s count got=%0d want=%0d", tag, StackCount, ecnt);
        end
        clr();
    endtask

    initial begin
        logic [15:0] t;
        clr();
        // Reset overrides a simultaneous jump; all outputs zero.
        Reset = 1'b1; JumpReq = 1'b1; Target = 16'sh1234;
        run("reset", mk(0, 0, 0, 0, 0, 0), 16'h0000, 3'd0);
        run("idle1", inc(0, 0), 16'h0001, 3'd0);
        run("idle2", inc(0, 0), 16'h0002, 3'd0);
        run("idle3", inc(0, 0), 16'h0003, 3'd0);

        JumpReq = 1'b1; Target = 16'sh000F;
        run("jump", load(16'h000F), 16'h000F, 3'd0);
        run("jump_post", inc(FL, 0), 16'h0010, 3'd0);

        BranchReq = 1'b1; BranchTaken = 1'b1; BranchOffset = -9'sd4;
        run("br_taken", mk(0, 0, 1, 9'h1FC, 0, 0), 16'h000C, 3'd0);
        run("br_post", inc(FL, 0), 16'h000D, 3'd0);
        BranchReq = 1'b1; BranchTaken = 1'b0; BranchOffset = 9'sd5;
        run("br_not", inc(0, 0), 16'h000E, 3'd0);
        run("br_not_post", inc(0, 0), 16'h000F, 3'd0);
        BranchReq = 1'b1; BranchTaken = 1'b1; BranchOffset = 9'sd0;
        run("br_zero", mk(0, 0, 1, 0, 0, 0), 16'h000F, 3'd0);
        run("br_zero_post", inc(FL, 0), 16'h0010, 3'd0);

        JumpReq = 1'b1; Target = 16'sh001F;
        run("jump1f", load(16'h001F), 16'h001F, 3'd0);
        run("jump1f_post", inc(FL, 0), 16'h0020, 3'd0);
        CallReq = 1'b1; Target = 16'sh0100;
        run("call", load(16'h0100), 16'h0100, 3'd1);
        run("call_post", inc(FL, 0), 16'h0101, 3'd1);
        for (int i = 0; i < 4; i++)
            run("call_body", inc(0, 0), 16'h0102 + 16'(i), 3'd1);
        ReturnReq = 1'b1;
        run("ret", load(16'h0021), 16'h0021, 3'd0);
        run("ret_post", inc(FL, 0), 16'h0022, 3'd0);

        // Call outranks jump, branch and halt.
        CallReq = 1'b1; JumpReq = 1'b1; BranchReq = 1'b1; BranchTaken = 1'b1;
        BranchOffset = 9'sd7; HaltReq = 1'b1; Target = 16'sh0200;
        run("prio_call", load(16'h0200), 16'h0200, 3'd1);
        // Post-redirect request: ignored with the flush stage, honoured without.
        JumpReq = 1'b1; Target = 16'sh0300;
        run("post_jump", FL ? inc(1, 0) : load(16'h0300), FL ? 16'h0201 : 16'h0300, 3'd1);
        run("post_jump_idle", inc(0, 0), FL ? 16'h0202 : 16'h0301, 3'd1);
        // Return outranks call and jump.
        ReturnReq = 1'b1; CallReq = 1'b1; JumpReq = 1'b1; Target = 16'sh0500;
        run("prio_ret", load(16'h0023), 16'h0023, 3'd0);
        run("prio_ret_post", inc(FL, 0), 16'h0024, 3'd0);

        // Return address wraps 0x7FFF -> 0x8000.
        JumpReq = 1'b1; Target = 16'sh7FFE;
        run("jump7ffe", load(16'h7FFE), 16'h7FFE, 3'd0);
        run("jump7ffe_post", inc(FL, 0), 16'h7FFF, 3'd0);
        CallReq = 1'b1; Target = 16'sh0050;
        run("call_wrap", load(16'h0050), 16'h0050, 3'd1);
        run("call_wrap_post", inc(FL, 0), 16'h0051, 3'd1);
        ReturnReq = 1'b1;
        run("ret_wrap", load(16'h8000), 16'h8000, 3'd0);
        run("ret_wrap_post", inc(FL, 0), 16'h8001, 3'd0);

        Stall = 1'b1; JumpReq = 1'b1; Target = 16'sh0099;
        run("stall_jump", hold(0, 0), 16'h8001, 3'd0);
        JumpReq = 1'b1; Target = 16'sh003E;
        run("jump3e", load(16'h003E), 16'h003E, 3'd0);
        Stall = 1'b1;
        run("stall_post", hold(FL, 0), 16'h003E, 3'd0);
        run("stall_post_rel", inc(FL, 0), 16'h003F, 3'd0);
        // Branch (not taken) outranks halt: halt is dropped.
        BranchReq = 1'b1; HaltReq = 1'b1;
        run("br_over_halt", inc(0, 0), 16'h0040, 3'd0);
        HaltReq = 1'b1;
        run("halt", hold(0, 0), 16'h0040, 3'd0);
        for (int i = 0; i < 10; i++) begin
            JumpReq = 1'b1; CallReq = i[0]; Target = 16'sh0777;
            run("halted", hold(0, 0), 16'h0040, 3'd0);
        end
        ResumeReq = 1'b1;
        run("resume", hold(0, 0), 16'h0040, 3'd0);
        run("resume_post", inc(0, 0), 16'h0041, 3'd0);

        // Underflow faults; FAULT holds and ignores requests until reset.
        ReturnReq = 1'b1; JumpReq = 1'b1; Target = 16'sh0123;
        run("ret_empty", hold(0, 0), 16'h0041, 3'd0);
        run("fault1", hold(0, 1), 16'h0041, 3'd0);
        JumpReq = 1'b1; Target = 16'sh0123;
        run("fault2", hold(0, 1), 16'h0041, 3'd0);
        Reset = 1'b1;
        run("reset_fault", mk(0, 0, 0, 0, 0, 0), 16'h0000, 3'd0);
        run("after_reset", inc(0, 0), 16'h0001, 3'd0);

        // Reset during the post-redirect cycle.
        JumpReq = 1'b1; Target = 16'sh0010;
        run("jump_pre_rst", load(16'h0010), 16'h0010, 3'd0);
        Reset = 1'b1;
        run("reset_flush", mk(0, 0, 0, 0, 0, 0), 16'h0000, 3'd0);
        run("after_reset2", inc(0, 0), 16'h0001, 3'd0);

        // Overflow: four calls fill the stack, the fifth faults.
        for (int i = 0; i < 4; i++) begin
            t = 16'h0100 * 16'(i + 1);
            CallReq = 1'b1; Target = t;
            run("fill_call", load(t), t, 3'(i + 1));
            run("fill_post", inc(FL, 0), t + 16'h1, 3'(i + 1));
        end
        CallReq = 1'b1; Target = 16'sh0900;
        run("call_full", hold(0, 0), 16'h0401, 3'd4);
        for (int i = 0; i < 3; i++)
            run("ovf_fault", hold(0, 1), 16'h0401, 3'd4);
        Reset = 1'b1;
        run("reset_ovf", mk(0, 0, 0, 0, 0, 0), 16'h0000, 3'd0);
        run("after_reset3", inc(0, 0), 16'h0001, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control sequencer for the program counter. It turns decoded control-flow requests (branch, jump, call, return, halt) into the counter's load/offset controls and keeps a small hardware return-address stack. When built with the flush option, it also emits a one-cycle flush pulse after every taken redirect. It sits between the decode stage and the program counter, and drives the counter's LoadValue, LoadEnable, Offset and OffsetEnable inputs directly.

## Interface
- STACK_DEPTH, 4: return-address stack entries; minimum 1.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- CurrentPc  in  16 signed  present counter value.
- Stall  in  1  hold the PC; all requests ignored.
- BranchReq  in  1  conditional relative branch.
- BranchTaken  in  1  branch condition; sampled only with BranchReq.
- BranchOffset  in  9 signed  branch displacement.
- JumpReq  in  1  absolute jump.
- CallReq  in  1  absolute jump plus push of the return address.
- Target  in  16 signed  destination for jump and call.
- ReturnReq  in  1  pop the stack and load the popped value.
- HaltReq  in  1  enter HALTED.
- ResumeReq  in  1  leave HALTED.
- LoadValue  out  16 signed  to the counter.
- LoadEnable  out  1  to the counter.
- Offset  out  9 signed  to the counter.
- OffsetEnable  out  1  to the counter.
- Flush  out  1  discard the instruction currently in fetch.
- Fault  out  1  sticky stack overflow/underflow indication.
- StackCount  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.

## Operation
- Registered state: FSM state (RUN, FLUSH, HALTED, FAULT), the stack array and StackCount.
- All counter controls are combinational from the FSM state and the inputs.
- Control encodings:
  - Increment: LoadEnable=0, OffsetEnable=0.
  - Hold: OffsetEnable=1, Offset=0.
  - Defaults: LoadValue=0 and Offset=0 whenever the matching enable is low.
- RUN priority: Stall > ReturnReq > CallReq > JumpReq > BranchReq > HaltReq > increment. Lower-priority requests in the same cycle are dropped.
- Stall: hold; state unchanged.
- Return, stack not empty:
  - LoadValue = top entry, LoadEnable=1.
  - StackCount decrements; go to FLUSH.
- Return, stack empty: hold; go to FAULT.
- Call, stack not full:
  - Push CurrentPc+1, computed modulo 2^16 (16'sh7FFF -> 16'sh8000).
  - LoadValue = Target, LoadEnable=1; go to FLUSH.
- Call, stack full: hold; no push; go to FAULT.
- Jump: LoadValue = Target, LoadEnable=1; go to FLUSH.
- Branch taken: Offset = BranchOffset, OffsetEnable=1; go to FLUSH. This applies even when the offset is 0.
- Branch not taken: increment; stay in RUN.
- Halt: hold; go to HALTED.
- FLUSH:
  - Flush=1; all requests ignored.
  - Stall=0: increment, return to RUN.
  - Stall=1: hold, remain in FLUSH.
- HALTED: hold.
  - ResumeReq=1: go to RUN; the increment resumes the following cycle.
  - Other requests are ignored.
- FAULT: Fault=1, hold every cycle. Left only by Reset.

## Timing
- Reset cycle:
  - All outputs are 0 (LoadEnable, OffsetEnable, Offset, LoadValue, Flush, Fault).
  - Next state RUN; StackCount=0; stack contents become don't-care.
- Zero-cycle control latency: a request in cycle N sets the counter value after edge N. The stack and FSM update on the same edge.
- Flush is high for exactly the cycle after a redirect (longer only under Stall).
- Reset asserted in any state, including mid-FLUSH or FAULT, overrides everything on that edge.

## Configuration
- PC_SEQ_FLUSH_EN defined:
  - FLUSH state present as described.
- PC_SEQ_FLUSH_EN undefined:
  - No FLUSH state; redirects return straight to RUN.
  - Requests in the cycle after a redirect are honoured.
  - Flush is tied to 0.

## Test plan
- Reset, then 3 idle cycles -> LoadEnable=0, OffsetEnable=0 each cycle; PC 0 -> 3.
- At PC=0x0010, BranchReq, BranchTaken=1, BranchOffset=-4 -> Offset=-4, OffsetEnable=1. PC=0x000C; Flush=1 next cycle; PC=0x000D after.
- At PC=0x0020, CallReq with Target=0x0100 -> PC=0x0100, StackCount=1. ReturnReq at 0x0105 -> PC=0x0021, StackCount=0.
- With STACK_DEPTH=4, issue 5 calls -> 5th gives hold and Fault=1. PC stays frozen until Reset; Reset clears Fault and StackCount.
- ReturnReq with empty stack -> hold, Fault=1. Stall=1 together with JumpReq -> hold, no jump.
- HaltReq at PC=0x0040 -> PC held at 0x0040 for 10 cycles. ResumeReq -> PC=0x0041 two cycles later.
